clock_period_meter: RTL and testbench
=====================================

CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

Interface
REQ-001 Parameter N, default 8, is the width of all counters and measurement outputs.
REQ-002 clock_in  input  1  the single system clock; all logic is clocked on its rising edge.
REQ-003 reset_n  input  1  reset; synchronous and active-low.
REQ-004 enable  input  1  measurement enable; 0 forces IDLE.
REQ-005 sig_in  input  1  divided clock to be measured; asynchronous to clock_in.
REQ-006 period  output  N  clock_in cycles between the last two sig_in rising edges.
REQ-007 high_time  output  N  clock_in cycles sig_in was high within that period.
REQ-008 valid  output  1  one-cycle pulse when period/high_time are updated.
REQ-009 locked  output  1  two consecutive valid measurements had equal period.
REQ-010 overflow  output  1  sticky flag: no rising edge within 2^N-1 cycles.

Function
REQ-011 sig_in SHALL pass through a 2-flop synchronizer (s1, s2) plus a previous-value flop (s3); rise = s2 & ~s3, level = s2.
REQ-012 FSM states SHALL be IDLE, WAIT_EDGE, MEASURE and OVF.
REQ-013 IDLE: enable=1 -> WAIT_EDGE; the counters are held at 0.
REQ-014 WAIT_EDGE: rise -> MEASURE with cnt<=1 and hcnt<=1; no output update.
REQ-015 MEASURE, no rise: cnt<=cnt+1; hcnt<=hcnt+1 when level=1, else hold.
REQ-016 MEASURE, rise: period<=cnt, high_time<=hcnt, valid<=1, overflow<=0, then cnt<=1 and hcnt<=1; stay in MEASURE.
REQ-017 MEASURE, no rise with cnt=2^N-1: overflow<=1 -> OVF; no valid pulse; period/high_time hold.
REQ-018 OVF: rise -> MEASURE with cnt<=1 and hcnt<=1 (treated as a first edge, no valid); otherwise hold.
REQ-019 Latency: the first clock_in edge sampling sig_in=1 is edge k; valid SHALL be high in the cycle after edge k+2.
REQ-020 For a 50%-style divider of divisor D (high for floor(D/2) cycles), the steady-state result SHALL be period=D and high_time=floor(D/2).
REQ-021 locked SHALL be set on a valid whose period equals the previous valid period.
REQ-022 locked SHALL be cleared on a valid with an unequal period, on entry to OVF, and when enable=0.
REQ-023 enable=0 in any state -> IDLE next cycle; valid=0, locked=0; period, high_time and overflow hold.
REQ-024 valid SHALL be high for exactly one cycle per measurement and never in IDLE, WAIT_EDGE or OVF.
REQ-025 All arithmetic SHALL be unsigned N-bit; cnt never wraps (bounded by REQ-017).

Reset
REQ-026 reset_n=0 at a clock_in edge: state<=IDLE; cnt, hcnt, period, high_time <= 0; valid, locked, overflow <= 0; s1, s2, s3 <= 0.
REQ-027 reset_n SHALL take priority over enable and sig_in; reset mid-measurement discards the partial count.
REQ-028 After reset release, the first valid SHALL require two observed rising edges.

Verification
REQ-029 N=8, enable=1, sig_in from divider D=8 -> valid once every 8 cycles, period=8, high_time=4, locked=1 from the second valid.
REQ-030 D=5 -> period=5, high_time=2; D switched 8->6 mid-stream -> one transitional valid with locked=0, then period=6 and locked=1 on the following valid.
REQ-031 sig_in held at 0 after one rising edge -> overflow=1 and locked=0 exactly 255 cycles after the edge-detect cycle, no valid; resume D=8 -> second new edge gives valid with period=8 and overflow=0.
REQ-032 reset_n=0 for 1 cycle midway through a D=8 period -> all outputs 0 next cycle; first valid only after two new rising edges.
REQ-033 enable dropped for 3 cycles during lock -> valid=0 and locked=0, period holds 8; re-enable -> relock after two valids.
REQ-034 Edge latency: single isolated sig_in rise at edge k (state MEASURE) -> valid high in the cycle after edge k+2, checked cycle-exact.

Source files
------------

// File: rtl/clock_period_meter.sv
// Measures the period and high time of a slow, asynchronous sig_in in clock_in cycles,
// with lock detection on repeated equal periods and a sticky overflow on a missing edge.
module clock_period_meter #(
  parameter int unsigned N = 8
) (
  input  logic         clock_in,
  input  logic         reset_n,
  input  logic         enable,
  input  logic         sig_in,
  output logic [N-1:0] period,
  output logic [N-1:0] high_time,
  output logic         valid,
  output logic         locked,
  output logic         overflow
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_EDGE = 2'd1;
  localparam logic [1:0] MEASURE   = 2'd2;
  localparam logic [1:0] OVF       = 2'd3;

  localparam logic [N-1:0] CNT_ONE = N'(1);
  localparam logic [N-1:0] CNT_MAX = {N{1'b1}};

  logic [1:0]   state, state_nx;
  logic [N-1:0] cnt, cnt_nx;
  logic [N-1:0] hcnt, hcnt_nx;
  logic [N-1:0] period_nx, high_time_nx;
  logic         valid_nx, locked_nx, overflow_nx;
  logic         has_prev, has_prev_nx;
  logic         s1, s2, s3;
  logic         rise_c, level_c;

  assign rise_c  = s2 & ~s3;
  assign level_c = s2;

  // Synchronizer, state and all registered outputs
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      hcnt      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      overflow  <= 1'b0;
      has_prev  <= 1'b0;
    end else begin
      s1        <= sig_in;
      s2        <= s1;
      s3        <= s2;
      state     <= state_nx;
      cnt       <= cnt_nx;
      hcnt      <= hcnt_nx;
      period    <= period_nx;
      high_time <= high_time_nx;
      valid     <= valid_nx;
      locked    <= locked_nx;
      overflow  <= overflow_nx;
      has_prev  <= has_prev_nx;
    end
  end

  // has_prev marks that period holds a result from this run, so lock needs two fresh valids
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    hcnt_nx      = hcnt;
    period_nx    = period;
    high_time_nx = high_time;
    valid_nx     = 1'b0;
    locked_nx    = locked;
    overflow_nx  = overflow;
    has_prev_nx  = has_prev;

    if (!enable) begin
      state_nx    = IDLE;
      cnt_nx      = '0;
      hcnt_nx     = '0;
      locked_nx   = 1'b0;
      has_prev_nx = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = WAIT_EDGE;
          cnt_nx   = '0;
          hcnt_nx  = '0;
        end
        WAIT_EDGE: begin
          if (rise_c) begin
            state_nx = MEASURE;
            cnt_nx   = CNT_ONE;
            hcnt_nx  = CNT_ONE;
          end
        end
        MEASURE: begin
          if (rise_c) begin
            period_nx    = cnt;
            high_time_nx = hcnt;
            valid_nx     = 1'b1;
            overflow_nx  = 1'b0;
            locked_nx    = has_prev && (cnt == period);
            has_prev_nx  = 1'b1;
            cnt_nx       = CNT_ONE;
            hcnt_nx      = CNT_ONE;
          end else if (cnt == CNT_MAX) begin
            overflow_nx = 1'b1;
            locked_nx   = 1'b0;
            has_prev_nx = 1'b0;
            state_nx    = OVF;
          end else begin
            cnt_nx = cnt + CNT_ONE;
            if (level_c) begin
              hcnt_nx = hcnt + CNT_ONE;
            end
          end
        end
        OVF: begin
          if (rise_c) begin
            state_nx = MEASURE;
            cnt_nx   = CNT_ONE;
            hcnt_nx  = CNT_ONE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Self-checking bench for clock_period_meter: a timestamp-based model of sig_in rises
// is compared every cycle, plus hand-computed expectations at key points.
module tb_clock_period_meter;

  localparam int unsigned N = 8;
  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_MEAS = 2;
  localparam int M_OVF  = 3;

  logic         clock_in = 1'b0;
  logic         reset_n  = 1'b0;
  logic         enable   = 1'b0;
  logic         sig_in   = 1'b0;
  logic [N-1:0] period;
  logic [N-1:0] high_time;
  logic         valid;
  logic         locked;
  logic         overflow;

  always #5 clock_in = ~clock_in;

  clock_period_meter #(.N(N)) dut (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .enable   (enable),
    .sig_in   (sig_in),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .locked   (locked),
    .overflow (overflow)
  );

  int errors = 0;
  int checks = 0;

  // Model state: sample history by clock edge index and the index of the last rise sample
  int cyc = 0;
  bit samp [0:16383];
  int mode = M_IDLE;
  int m_last = 0;
  int m_period = 0;
  int m_high = 0;
  bit m_valid = 1'b0;
  bit m_locked = 1'b0;
  bit m_ovf = 1'b0;
  bit m_has_prev = 1'b0;
  bit chk_en = 1'b0;

  // Stimulus controls
  logic r_q = 1'b0;
  logic e_q = 1'b0;
  int   dv = 8;
  int   ph = 0;
  bit   manual = 1'b1;
  logic man_sig = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Period = distance between rising samples; high_time = high samples inside that window
  task automatic model_step();
    int  t;
    bit  rise;
    int  p;
    int  h;
    t = cyc;
    m_valid = 1'b0;
    if (!reset_n) begin
      mode = M_IDLE;
      m_period = 0;
      m_high = 0;
      m_locked = 1'b0;
      m_ovf = 1'b0;
      m_has_prev = 1'b0;
      m_last = 0;
      samp[t] = 1'b0;
      if (t >= 1) samp[t-1] = 1'b0;
      if (t >= 2) samp[t-2] = 1'b0;
      chk_en = 1'b1;
    end else begin
      samp[t] = sig_in;
      rise = (t >= 3) && samp[t-2] && !samp[t-3];
      if (!enable) begin
        mode = M_IDLE;
        m_locked = 1'b0;
        m_has_prev = 1'b0;
      end else begin
        case (mode)
          M_IDLE: mode = M_WAIT;
          M_WAIT: if (rise) begin mode = M_MEAS; m_last = t - 2; end
          M_MEAS: begin
            if (rise) begin
              p = (t - 2) - m_last;
              h = 0;
              for (int i = m_last; i <= t - 3; i++) h += int'(samp[i]);
              m_locked = m_has_prev && (p == m_period);
              m_period = p;
              m_high = h;
              m_valid = 1'b1;
              m_ovf = 1'b0;
              m_has_prev = 1'b1;
              m_last = t - 2;
            end else if ((t - 2) - m_last == 255) begin
              m_ovf = 1'b1;
              m_locked = 1'b0;
              m_has_prev = 1'b0;
              mode = M_OVF;
            end
          end
          M_OVF: if (rise) begin mode = M_MEAS; m_last = t - 2; end
          default: mode = M_IDLE;
        endcase
      end
    end
    cyc++;
  endtask

  initial begin
    forever begin
      @(posedge clock_in);
      model_step();
    end
  end

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clock_in);
      if (chk_en) begin
        chk("valid",     32'(valid),     32'(m_valid));
        chk("locked",    32'(locked),    32'(m_locked));
        chk("overflow",  32'(overflow),  32'(m_ovf));
        chk("period",    32'(period),    32'(m_period));
        chk("high_time", 32'(high_time), 32'(m_high));
      end
    end
  end

  task automatic tick();
    @(negedge clock_in);
    reset_n = r_q;
    enable  = e_q;
    if (manual) begin
      sig_in = man_sig;
    end else begin
      if (ph >= dv) ph = 0;
      sig_in = (ph < dv / 2);
      ph++;
      if (ph >= dv) ph = 0;
    end
  endtask

  task automatic wait_valid(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got no valid expected a valid within 400 cycles", tag);
    end
  endtask

  initial begin
    // Reset
    r_q = 1'b0; e_q = 1'b0; manual = 1'b1; man_sig = 1'b0;
    tick(); tick();
    r_q = 1'b1; e_q = 1'b1;
    tick();
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_high", 32'(high_time), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // D=8 steady state
    manual = 1'b0; dv = 8; ph = 0;
    repeat (40) tick();
    wait_valid("d8");
    chk("d8_period", 32'(period), 32'd8);
    chk("d8_high", 32'(high_time), 32'd4);
    chk("d8_locked", 32'(locked), 32'd1);

    // D=5
    dv = 5;
    repeat (30) tick();
    wait_valid("d5");
    chk("d5_period", 32'(period), 32'd5);
    chk("d5_high", 32'(high_time), 32'd2);
    chk("d5_locked", 32'(locked), 32'd1);

    // D switched 8 -> 6 right after a valid
    dv = 8;
    repeat (30) tick();
    wait_valid("pre_sw");
    chk("pre_sw_locked", 32'(locked), 32'd1);
    dv = 6;
    wait_valid("sw_first");
    chk("sw_first_locked", 32'(locked), 32'd0);
    chk("sw_first_period", 32'(period), 32'd6);
    wait_valid("sw_second");
    chk("sw_period", 32'(period), 32'd6);
    chk("sw_high", 32'(high_time), 32'd3);
    chk("sw_locked", 32'(locked), 32'd1);

    // Enable dropped for 3 cycles while locked at D=8
    dv = 8;
    wait_valid("en_a"); wait_valid("en_b");
    chk("en_pre_locked", 32'(locked), 32'd1);
    e_q = 1'b0;
    repeat (3) tick();
    chk("en_off_valid", 32'(valid), 32'd0);
    chk("en_off_locked", 32'(locked), 32'd0);
    chk("en_off_period", 32'(period), 32'd8);
    e_q = 1'b1;
    wait_valid("en_first");
    chk("en_first_locked", 32'(locked), 32'd0);
    chk("en_first_period", 32'(period), 32'd8);
    wait_valid("en_second");
    chk("en_relock", 32'(locked), 32'd1);

    // Overflow: last rise was at edge k, sig_in held low afterwards
    wait_valid("ovf_pre");
    manual = 1'b1; man_sig = 1'b0;
    for (int i = 4; i <= 257; i++) tick();
    chk("ovf_before", 32'(overflow), 32'd0);
    chk("ovf_before_locked", 32'(locked), 32'd1);
    tick();
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_locked", 32'(locked), 32'd0);
    manual = 1'b0; dv = 8; ph = 0;
    wait_valid("ovf_resume");
    chk("ovf_resume_period", 32'(period), 32'd8);
    chk("ovf_resume_ovf", 32'(overflow), 32'd0);
    chk("ovf_resume_locked", 32'(locked), 32'd0);

    // One-cycle reset midway through a D=8 period
    wait_valid("rm_pre");
    tick(); tick();
    r_q = 1'b0;
    tick();
    r_q = 1'b1;
    tick();
    chk("rm_period", 32'(period), 32'd0);
    chk("rm_high", 32'(high_time), 32'd0);
    chk("rm_valid", 32'(valid), 32'd0);
    chk("rm_locked", 32'(locked), 32'd0);
    chk("rm_ovf", 32'(overflow), 32'd0);
    wait_valid("rm_first");
    chk("rm_first_period", 32'(period), 32'd8);
    chk("rm_first_locked", 32'(locked), 32'd0);

    // Isolated rise at edge k while measuring: valid exactly after edge k+2
    wait_valid("lat_pre");
    manual = 1'b1; man_sig = 1'b0;
    repeat (20) tick();
    man_sig = 1'b1;
    tick(); tick();
    man_sig = 1'b0;
    tick();
    chk("lat_k1_valid", 32'(valid), 32'd0);
    tick();
    chk("lat_k2_valid", 32'(valid), 32'd1);
    tick();
    chk("lat_k3_valid", 32'(valid), 32'd0);
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
